// File: rtl/iter_mag_compare.sv
`default_nettype none
// ============================================================================
// Module      : iter_mag_compare
// Description : Multi-cycle signed/unsigned magnitude comparator, MSB chunk
//               first, early exit on the first differing chunk.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_mag_compare #(
   parameter  int WIDTH = 32,
   parameter  int CHUNK = 4,
   localparam int NCH   = WIDTH / CHUNK,
   localparam int CW    = $clog2(NCH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             agb,
   output logic             asb,
   output logic             aeb,
   output logic [CW-1:0]    cycles
);

   localparam int              IW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0]   IDX_LAST = IW'(NCH - 1);
   localparam logic [CW-1:0]   CYC_ALL  = CW'(NCH);

   if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("iter_mag_compare: WIDTH must be a non-zero multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   ra_q, ra_d;
   logic [WIDTH-1:0]   rb_q, rb_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               agb_q, agb_d;
   logic               asb_q, asb_d;
   logic               aeb_q, aeb_d;
   logic [CW-1:0]      cycles_q, cycles_d;

   logic [CHUNK-1:0]   w_a_chunks [NCH];
   logic [CHUNK-1:0]   w_b_chunks [NCH];
   logic [CHUNK-1:0]   w_a_chunk;
   logic [CHUNK-1:0]   w_b_chunk;

   for (genvar g = 0; g < NCH; g++) begin : g_chunk
      assign w_a_chunks[g] = ra_q[g*CHUNK +: CHUNK];
      assign w_b_chunks[g] = rb_q[g*CHUNK +: CHUNK];
   end

   assign w_a_chunk = w_a_chunks[idx_q];
   assign w_b_chunk = w_b_chunks[idx_q];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ra_q     <= '0;
         rb_q     <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         agb_q    <= 1'b0;
         asb_q    <= 1'b0;
         aeb_q    <= 1'b0;
         cycles_q <= '0;
      end else begin
         ra_q     <= ra_d;
         rb_q     <= rb_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         agb_q    <= agb_d;
         asb_q    <= asb_d;
         aeb_q    <= aeb_d;
         cycles_q <= cycles_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ra_d     = ra_q;
      rb_d     = rb_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      agb_d    = agb_q;
      asb_d    = asb_q;
      aeb_d    = aeb_q;
      cycles_d = cycles_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Flipping the sign bit maps two's complement onto offset
               // binary, so the chunk walk below stays purely unsigned.
               ra_d            = a;
               rb_d            = b;
               ra_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
               rb_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
               idx_d           = IDX_LAST;
               cnt_d           = '0;
               state_d         = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (w_a_chunk != w_b_chunk) begin
               agb_d    = (w_a_chunk > w_b_chunk);
               asb_d    = (w_a_chunk < w_b_chunk);
               aeb_d    = 1'b0;
               cycles_d = cnt_q + CW'(1);
               state_d  = DONE;
            end else if (idx_q == '0) begin
               agb_d    = 1'b0;
               asb_d    = 1'b0;
               aeb_d    = 1'b1;
               cycles_d = CYC_ALL;
               state_d  = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign agb       = agb_q;
   assign asb       = asb_q;
   assign aeb       = aeb_q;
   assign cycles    = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_mag_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_mag_compare
// Description : Scoreboard bench for iter_mag_compare (WIDTH=32, CHUNK=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_mag_compare;

   localparam int WIDTH = 32;
   localparam int CHUNK = 4;
   localparam int CW    = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             agb;
   logic             asb;
   logic             aeb;
   logic [CW-1:0]    cycles;

   typedef struct packed {
      logic          agb;
      logic          asb;
      logic          aeb;
      logic [CW-1:0] cycles;
   } res_t;

   res_t exp_q[$];
   res_t mon_got;
   res_t mon_exp;
   int   checks   = 0;
   int   failures = 0;

   iter_mag_compare #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .agb         (agb),
      .asb         (asb),
      .aeb         (aeb),
      .cycles      (cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic res_t mk(input logic g, input logic s, input logic e, input int c);
      res_t r;
      r.agb    = g;
      r.asb    = s;
      r.aeb    = e;
      r.cycles = CW'(c);
      return r;
   endfunction

   // Scoreboard monitor: pops one expectation per output handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         mon_got = '{agb, asb, aeb, cycles};
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=0x%0h required=none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            check("result", 32'(mon_got), 32'(mon_exp));
            check("onehot", 32'($countones({agb, asb, aeb})), 32'd1);
         end
      end
   end

   task automatic wait_ready(input string name);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
   endtask

   task automatic wait_out(input string name, input int req_lat);
      int lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, "_latency"}, 32'(lat), 32'(req_lat));
   endtask

   // Full transaction with out_ready held high; signed_mode is flipped after
   // accept to show it is only sampled at the accept edge.
   task automatic run(input string name, input logic [31:0] va, input logic [31:0] vb,
                      input logic sm, input res_t e);
      exp_q.push_back(e);
      wait_ready(name);
      a           = va;
      b           = vb;
      signed_mode = sm;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid    = 1'b0;
      signed_mode = ~sm;
      wait_out(name, int'(e.cycles));
      @(posedge clk); #1;
   endtask

   initial begin
      int stale;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      signed_mode = 1'b0;
      a           = '0;
      b           = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_flags",     32'({agb, asb, aeb}), 32'd0);
      check("rst_cycles",    32'(cycles),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      run("uns_msb",   32'h8000_0000, 32'h7FFF_FFFF, 1'b0, mk(1, 0, 0, 1));
      run("sgn_msb",   32'h8000_0000, 32'h7FFF_FFFF, 1'b1, mk(0, 1, 0, 1));
      run("equal",     32'h1234_5678, 32'h1234_5678, 1'b0, mk(0, 0, 1, 8));
      run("late_gt",   32'h0000_0005, 32'h0000_0003, 1'b0, mk(1, 0, 0, 8));
      run("late_lt",   32'h0000_0050, 32'h0000_0060, 1'b0, mk(0, 1, 0, 7));
      run("neg1_vs_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, mk(0, 1, 0, 1));
      run("neg8_neg3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, mk(0, 1, 0, 8));
      run("sgn_eq",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(0, 0, 1, 8));

      // Backpressure: result held while a new request waits at the input.
      exp_q.push_back(mk(1, 0, 0, 3));
      wait_ready("bp");
      a           = 32'h00F0_0000;
      b           = 32'h00E0_0000;
      signed_mode = 1'b0;
      in_valid    = 1'b1;
      out_ready   = 1'b0;
      @(posedge clk); #1;
      a = 32'h0000_0001;
      b = 32'h0000_0002;
      wait_out("bp", 3);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready",  32'(in_ready),  32'd0);
         check("bp_hold",      32'({agb, asb, aeb, cycles}), 32'({1'b1, 1'b0, 1'b0, 4'd3}));
         @(posedge clk); #1;
      end
      exp_q.push_back(mk(0, 1, 0, 8));
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_idle_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      check("bp_accepted", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      wait_out("bp2", 8);
      @(posedge clk); #1;

      // Asynchronous reset during the third RUN cycle.
      wait_ready("rst_run");
      a           = 32'hAAAA_AAAA;
      b           = 32'hAAAA_AAAA;
      signed_mode = 1'b0;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd1);
      check("mid_rst_flags",     32'({agb, asb, aeb}), 32'd0);
      check("mid_rst_cycles",    32'(cycles),    32'd0);
      @(negedge clk);
      rst   = 1'b0;
      stale = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      check("no_stale_result", 32'(stale), 32'd0);
      run("post_rst", 32'hAAAA_AAAA, 32'hAAAA_AAAB, 1'b0, mk(0, 1, 0, 8));

      repeat (2) @(posedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iter_mag_compare.md
Name: iter_mag_compare

Overview:
- Parametrised, multi-cycle magnitude comparator. Next generation of the team's 4-bit combinational greater/less/equal comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk. Stops at the first chunk that differs.
- Runtime signed/unsigned mode; valid/ready handshake on both input and output.
- Used in datapaths where a wide single-cycle compare would break timing.

Parameters:
- WIDTH, 32: operand width in bits. Must be ≥ CHUNK.
- CHUNK, 4: bits compared per cycle. WIDTH % CHUNK must be 0; elaboration fails otherwise.
- NCH (localparam), WIDTH/CHUNK: number of chunks.
- CW (localparam), $clog2(NCH)+1: width of the cycles output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode are presented.
- in_ready  out  1  block accepts operands (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned compare.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer accepts the result.
- agb  out  1  A > B.
- asb  out  1  A < B.
- aeb  out  1  A == B.
- cycles  out  CW  number of chunks examined for this result (1..NCH).

Behaviour:
- Reset (async assert, registered release):
  - state=IDLE, in_ready=1, out_valid=0.
  - agb=asb=aeb=0, cycles=0, internal operand and index registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: capture a, b into ra, rb.
  - If signed_mode=1, invert the MSB of both captured operands (offset-binary); all later comparison is unsigned.
  - idx=NCH-1, cnt=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle compare ra/rb chunk [idx*CHUNK +: CHUNK] unsigned; cnt increments.
  - Chunks differ: register agb/asb from that chunk compare, aeb=0, cycles=cnt+1, go to DONE.
  - Chunks equal and idx==0: aeb=1, agb=asb=0, cycles=NCH, go to DONE.
  - Otherwise: idx decrements, stay in RUN.
- DONE:
  - out_valid=1, in_ready=0.
  - agb/asb/aeb/cycles held stable until out_valid&&out_ready.
  - On that edge go to IDLE and deassert out_valid.
- Result outputs:
  - agb/asb/aeb are exactly one-hot whenever out_valid=1.
  - When out_valid=0 they hold the last result (0 after reset). Consumers must qualify them with out_valid.
- Latency: accept at edge E0. The result registers at edge Ek, where k = cycles (1..NCH), and out_valid rises after Ek.
- Throughput: the next operands are accepted no earlier than the edge after the output handshake, so at most 1 result per k+2 cycles.
- in_valid while busy: ignored. The operands are not captured; the source must hold them until in_ready.
- signed_mode: sampled only at accept. Changes during RUN/DONE have no effect.
- Reset mid-operation: the in-flight transaction is dropped with no partial result. All outputs take reset values immediately (asynchronous).
- WIDTH==CHUNK degenerate case: every compare completes with cycles=1.

Test Plan (WIDTH=32, CHUNK=4, NCH=8):
1. Unsigned early exit: a=0x8000_0000, b=0x7FFF_FFFF, signed_mode=0 -> agb=1, asb=0, aeb=0, cycles=1, out_valid high after the first edge following accept. Same operands with signed_mode=1 -> asb=1, cycles=1.
2. Equality: a=b=0x1234_5678 -> aeb=1, cycles=8, out_valid exactly 8 edges after accept.
3. Late difference: a=0x0000_0005, b=0x0000_0003 -> agb=1, cycles=8. Then a=0x0000_0050, b=0x0000_0060 -> asb=1, cycles=7.
4. Signed negatives: a=0xFFFF_FFFF (-1), b=0x0000_0001 -> asb=1, cycles=1. Then a=0xFFFF_FFF8 (-8), b=0xFFFF_FFFD (-3) -> asb=1, cycles=8.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands -> out_valid, agb/asb/aeb and cycles stay stable and in_ready=0 throughout. The new operands are accepted only on the first IDLE cycle after out_ready=1.
6. Reset mid-RUN: start a compare of a=b=0xAAAA_AAAA and assert rst on the 3rd RUN cycle, asynchronously -> same-cycle out_valid=0, agb=asb=aeb=0, cycles=0, in_ready=1 after release. No stale result appears, and the next transaction completes correctly.
